// File: rtl/uart_sensor_reporter.sv
// uart_sensor_reporter: snapshots DHT11/HC-SR04 readings on trigger and streams "H=hhh T=ttt D=ddd\r\n" to a byte UART transmitter.
// Ports:
//   clk, reset (sync, active-low)      system clock / reset
//   trigger                            single-cycle report request
//   humidity[7:0], temperature[7:0]    DHT11 readings
//   distance[8:0]                      HC-SR04 distance in cm
//   tx_busy, tx_done                   byte transmitter status
//   tx_start, tx_data[7:0]             byte launch pulse and held byte
//   busy, frame_done, err              frame in progress / completed / aborted on timeout
// Optional: define REPORT_CHECKSUM_EN to insert "*XX" (XOR of bytes 0..16, uppercase hex) before CR LF.
module uart_sensor_reporter #(
    parameter int         TX_TIMEOUT = 150_000,
    parameter logic [7:0] SEP_CHAR   = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    input  logic [8:0] distance,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);
`ifdef REPORT_CHECKSUM_EN
    localparam int LAST = 21;
`else
    localparam int LAST = 18;
`endif
    localparam int CW = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CONVERT, LOAD, START, WAIT, FINISH} state_t;
    state_t state;

    logic [7:0]    t_l;
    logic [8:0]    d_l;
    logic [8:0]    wv;
    logic [3:0]    hc;
    logic [3:0]    tc;
    logic [1:0]    fld;
    // digits shift in per field: [35:24]=H, [23:12]=T, [11:0]=D, each hundreds/tens/units
    logic [35:0]   digs;
    logic [4:0]    idx;
    logic [CW-1:0] cnt;
    logic [7:0]    byte_mux;

    function automatic logic [7:0] asc(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

`ifdef REPORT_CHECKSUM_EN
    logic [7:0] csum;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
`endif

    always_comb begin
        byte_mux = 8'h00;
        case (idx)
            5'd0:  byte_mux = "H";
            5'd1:  byte_mux = "=";
            5'd2:  byte_mux = asc(digs[35:32]);
            5'd3:  byte_mux = asc(digs[31:28]);
            5'd4:  byte_mux = asc(digs[27:24]);
            5'd5:  byte_mux = SEP_CHAR;
            5'd6:  byte_mux = "T";
            5'd7:  byte_mux = "=";
            5'd8:  byte_mux = asc(digs[23:20]);
            5'd9:  byte_mux = asc(digs[19:16]);
            5'd10: byte_mux = asc(digs[15:12]);
            5'd11: byte_mux = SEP_CHAR;
            5'd12: byte_mux = "D";
            5'd13: byte_mux = "=";
            5'd14: byte_mux = asc(digs[11:8]);
            5'd15: byte_mux = asc(digs[7:4]);
            5'd16: byte_mux = asc(digs[3:0]);
`ifdef REPORT_CHECKSUM_EN
            5'd17: byte_mux = "*";
            5'd18: byte_mux = hex(csum[7:4]);
            5'd19: byte_mux = hex(csum[3:0]);
            5'd20: byte_mux = 8'h0D;
            5'd21: byte_mux = 8'h0A;
`else
            5'd17: byte_mux = 8'h0D;
            5'd18: byte_mux = 8'h0A;
`endif
            default: byte_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            t_l        <= '0;
            d_l        <= '0;
            wv         <= '0;
            hc         <= '0;
            tc         <= '0;
            fld        <= '0;
            digs       <= '0;
            idx        <= '0;
            cnt        <= '0;
`ifdef REPORT_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: if (trigger) begin
                    wv    <= {1'b0, humidity};
                    t_l   <= temperature;
                    d_l   <= distance;
                    busy  <= 1'b1;
                    idx   <= '0;
                    fld   <= '0;
                    hc    <= '0;
                    tc    <= '0;
`ifdef REPORT_CHECKSUM_EN
                    csum  <= '0;
`endif
                    state <= CONVERT;
                end
                CONVERT: begin
                    if (wv >= 9'd100) begin
                        wv <= wv - 9'd100;
                        hc <= hc + 4'd1;
                    end else if (wv >= 9'd10) begin
                        wv <= wv - 9'd10;
                        tc <= tc + 4'd1;
                    end else begin
                        // remainder is the units digit; store field and load the next one
                        digs  <= {digs[23:0], hc, tc, wv[3:0]};
                        hc    <= '0;
                        tc    <= '0;
                        wv    <= (fld == 2'd0) ? {1'b0, t_l} : d_l;
                        fld   <= fld + 2'd1;
                        state <= (fld == 2'd2) ? LOAD : CONVERT;
                    end
                end
                LOAD: begin
                    tx_data <= byte_mux;
`ifdef REPORT_CHECKSUM_EN
                    // bytes 0..16 pass through here before the checksum digits are muxed
                    if (idx <= 5'd16) csum <= csum ^ byte_mux;
`endif
                    state   <= START;
                end
                START: if (!tx_busy) begin
                    tx_start <= 1'b1;
                    cnt      <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        idx   <= idx + 5'd1;
                        state <= (idx == 5'(LAST)) ? FINISH : LOAD;
                    end else if (cnt == CW'(TX_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FINISH: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_sensor_reporter.sv
// tb_uart_sensor_reporter: directed, table-driven bench for uart_sensor_reporter with a 20-cycle byte transmitter model.
module tb_uart_sensor_reporter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       trigger = 1'b0;
    logic [7:0] humidity = '0;
    logic [7:0] temperature = '0;
    logic [8:0] distance = '0;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_done;
    logic       err;

    always #5 clk = ~clk;

    uart_sensor_reporter #(.TX_TIMEOUT(1000)) dut (
        .clk(clk), .reset(reset), .trigger(trigger),
        .humidity(humidity), .temperature(temperature), .distance(distance),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // transmitter model: busy for 20 cycles after each tx_start, then tx_done (unless hang)
    logic [7:0] cap[$];
    int st_cyc[$];
    int n_start = 0, n_fd = 0, n_err = 0, n_unstable = 0;
    int done_cyc = 0, fd_cyc = 0, err_cyc = 0, ctr = 0;
    bit hang = 1'b0;

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (frame_done) begin n_fd++; fd_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; end
        if (tx_start) begin
            cap.push_back(tx_data);
            st_cyc.push_back(cyc);
            n_start++;
            tx_busy = 1'b1;
            ctr = 20;
        end else if (ctr > 0) begin
            if (busy && tx_data !== cap[cap.size()-1]) n_unstable++;
            ctr--;
            if (ctr == 0) begin
                tx_busy = 1'b0;
                if (!hang) begin tx_done = 1'b1; done_cyc = cyc; end
            end
        end
    end

    int total = 0, bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_max(input string nm, input int act, input int lim);
        total++;
        if (act > lim) begin
            bad++;
            $display("FAIL %s: got %0d expected <= %0d", nm, act, lim);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse_trig();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic wait_fd(input int f0, input string nm);
        int k = 0;
        while (n_fd == f0 && k < 3000) begin tick(); k++; end
        check({nm, "_fd_seen"}, n_fd - f0, 1);
    endtask

    task automatic wait_starts(input int n, input string nm);
        int k = 0;
        while (n_start < n && k < 1000) begin tick(); k++; end
        check({nm, "_starts_reached"}, int'(n_start >= n), 1);
    endtask

    task automatic check_frame(input string nm, input int base, input string exp);
        check({nm, "_len"}, cap.size() - base, exp.len());
        for (int i = 0; i < exp.len(); i++)
            if (base + i < cap.size())
                check($sformatf("%s_byte%0d", nm, i), int'(cap[base+i]), int'(exp.getc(i)));
    endtask

    function automatic string exp_of(input string s);
`ifdef REPORT_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 17; i++) x ^= s.getc(i);
        return $sformatf("%s*%02X\r\n", s.substr(0, 16), x);
`else
        return s;
`endif
    endfunction

    task automatic run_frame(input logic [7:0] h, input logic [7:0] t, input logic [8:0] d,
                             input string exp, input string nm);
        int base = cap.size();
        int ns0 = n_start;
        int f0 = n_fd;
        int tc;
        humidity = h; temperature = t; distance = d;
        tc = cyc;
        pulse_trig();
        wait_fd(f0, nm);
        check_frame(nm, base, exp);
        if (st_cyc.size() > ns0) check_max({nm, "_latency"}, st_cyc[ns0] - tc, 52);
        check({nm, "_fd_after_done"}, fd_cyc - done_cyc, 2);
        check({nm, "_busy_end"}, int'(busy), 0);
        tick(30);
        check({nm, "_starts"}, n_start - ns0, exp.len());
        check({nm, "_fd_once"}, n_fd - f0, 1);
    endtask

    typedef struct {
        logic [7:0] h;
        logic [7:0] t;
        logic [8:0] d;
        string      s;
    } vec_t;

    vec_t v[5];

    initial begin
        int base, ns0, f0, e0, k;
        v[0] = '{8'd45,  8'd23,  9'd123, "H=045 T=023 D=123\r\n"};
        v[1] = '{8'd255, 8'd255, 9'd511, "H=255 T=255 D=511\r\n"};
        v[2] = '{8'd0,   8'd0,   9'd0,   "H=000 T=000 D=000\r\n"};
        v[3] = '{8'd9,   8'd99,  9'd100, "H=009 T=099 D=100\r\n"};
        v[4] = '{8'd100, 8'd10,  9'd1,   "H=100 T=010 D=001\r\n"};

        tick(3);
        check("reset_outputs", int'({tx_start, tx_data, busy, frame_done, err}), 0);
        reset = 1'b1;
        tick(2);

        for (int i = 0; i < 5; i++) run_frame(v[i].h, v[i].t, v[i].d, exp_of(v[i].s), $sformatf("vec%0d", i));

`ifdef REPORT_CHECKSUM_EN
        run_frame(8'd0, 8'd0, 9'd0, "H=000 T=000 D=000*55\r\n", "zero_csum");
`endif

        // retrigger and input changes mid-frame have no effect
        base = cap.size(); ns0 = n_start; f0 = n_fd;
        humidity = 8'd12; temperature = 8'd34; distance = 9'd56;
        pulse_trig();
        wait_starts(ns0 + 6, "retrig");
        humidity = 8'd99; temperature = 8'd99; distance = 9'd99;
        pulse_trig();
        wait_fd(f0, "retrig");
        check_frame("retrig", base, exp_of("H=012 T=034 D=056\r\n"));
        tick(60);
        check("retrig_no_extra", n_start - ns0, exp_of("H=012 T=034 D=056\r\n").len());

        // transmitter never answers: abort after 1000 cycles
        hang = 1'b1;
        ns0 = n_start; e0 = n_err;
        pulse_trig();
        wait_starts(ns0 + 1, "timeout");
        k = 0;
        while (n_err == e0 && k < 1500) begin tick(); k++; end
        check("timeout_err_seen", n_err - e0, 1);
        if (st_cyc.size() > ns0) check("timeout_delay", err_cyc - st_cyc[ns0], 1000);
        check("timeout_busy", int'(busy), 0);
        tick(60);
        check("timeout_no_more_start", n_start - ns0, 1);
        check("timeout_err_once", n_err - e0, 1);
        hang = 1'b0;
        tick(5);

        // reset during byte 8, then a fresh frame
        ns0 = n_start;
        humidity = 8'd77; temperature = 8'd88; distance = 9'd99;
        pulse_trig();
        wait_starts(ns0 + 9, "midrst");
        tick(5);
        reset = 1'b0;
        tick();
        check("midrst_outputs", int'({tx_start, tx_data, busy, frame_done, err}), 0);
        reset = 1'b1;
        tick(30);
        check("midrst_idle", n_start - ns0, 9);
        run_frame(8'd1, 8'd2, 9'd3, exp_of("H=001 T=002 D=003\r\n"), "after_rst");

        check("tx_data_stable", n_unstable, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
